// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad scanner.
//   kp_state_t      : scanner FSM states (SCAN, PRESS_DB, HELD, RELEASE_DB)
//   clog2_min1()    : ceil(log2(n)) but never below 1, for counter/index widths
//   key_code_width(): width of the key_code output for a ROWS x COLS matrix
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int key_code_width(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

endpackage

// File: rtl/row_sync.sv
// -----------------------------------------------------------------------------
// row_sync
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Both stages reset to all ones so that "no key pressed" is seen during and
// right after reset.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   d     : raw row lines (asynchronous to clk)
//   q     : synchronized row lines
// -----------------------------------------------------------------------------
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '1;
            q      <= '1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// Matrix keypad scanner with press and release debouncing, no rollover.
// Columns are driven one-cold; rows are read active-low through row_sync.
// All FSM decisions happen on the internal scan tick (one clk every SCAN_DIV).
//
// Handshake: key_valid is a single-clk pulse with key_code already valid in
// the same cycle; there is no ready, the consumer must take it that cycle.
// key_code then holds until the next accepted press.
//
// Ports
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   keypad_hori : raw row lines, active-low, asynchronous [ROWS]
//   keypad_vert : column drive, one-cold [COLS]
//   key_code    : last accepted key, row*COLS + col
//   key_valid   : one-clk pulse on each accepted press
//   key_held    : high from acceptance until debounced release completes
//   dbg_state   : current FSM state encoding (kp_state_t)
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 192000,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ROWS-1:0]                        keypad_hori,
    output logic [COLS-1:0]                        keypad_vert,
    output logic [key_code_width(ROWS, COLS)-1:0]  key_code,
    output logic                                   key_valid,
    output logic                                   key_held,
    output logic [1:0]                             dbg_state
);

    localparam int KW  = key_code_width(ROWS, COLS);
    localparam int RW  = clog2_min1(ROWS);
    localparam int CLW = clog2_min1(COLS);
    localparam int DW  = clog2_min1(SCAN_DIV);
    localparam int CW  = clog2_min1(DEBOUNCE_CYCLES + 1);

    // ---------------- row synchronizer ----------------
    logic [ROWS-1:0] row_sync_q;

    row_sync #(.WIDTH(ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (keypad_hori),
        .q     (row_sync_q)
    );

    logic [ROWS-1:0] row_act;
    logic            any_row;
    logic [RW-1:0]   low_row;

    assign row_act = ~row_sync_q;
    assign any_row = |row_act;

    // Downward scan so the lowest active index is the last one written.
    always_comb begin
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row_act[i]) low_row = RW'(i);
        end
    end

    // ---------------- scan tick divider ----------------
    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    // ---------------- FSM ----------------
    kp_state_t      state, state_n;
    logic [CLW-1:0] col, col_n, col_inc;
    logic [RW-1:0]  row_lat, row_lat_n;
    logic [CW-1:0]  db_cnt, db_cnt_n;
    logic [KW-1:0]  code_n;
    logic           valid_n, held_n;
    logic           db_last;

    assign col_inc = (col == CLW'(COLS - 1)) ? '0 : col + CLW'(1);
    // True on the tick whose increment makes the count reach DEBOUNCE_CYCLES.
    assign db_last = (db_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_SCAN;
            col       <= '0;
            row_lat   <= '0;
            db_cnt    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row_lat   <= row_lat_n;
            db_cnt    <= db_cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_lat_n = row_lat;
        db_cnt_n  = db_cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        held_n    = key_held;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (!any_row) begin
                        col_n = col_inc;
                    end else begin
                        row_lat_n = low_row;
                        db_cnt_n  = '0;
                        state_n   = ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    // Column stays frozen; a mismatch drops back to SCAN on
                    // the same column so the key is re-examined next tick.
                    if (any_row && (low_row == row_lat)) begin
                        db_cnt_n = db_cnt + CW'(1);
                        if (db_last) begin
                            state_n = ST_HELD;
                            code_n  = KW'(int'(row_lat) * COLS + int'(col));
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end
                    end else begin
                        state_n = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any row on the frozen column keeps the hold (no rollover).
                    if (!any_row) begin
                        db_cnt_n = '0;
                        state_n  = ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (any_row) begin
                        state_n = ST_HELD;
                    end else begin
                        db_cnt_n = db_cnt + CW'(1);
                        if (db_last) begin
                            held_n  = 1'b0;
                            col_n   = col_inc;
                            state_n = ST_SCAN;
                        end
                    end
                end
                default: state_n = ST_SCAN;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign keypad_vert = ~(COLS'(1) << col);
    assign dbg_state   = state;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad row (horizontal) inputs, range 2..8.
REQ-002 SHALL have parameter COLS, default 4, number of keypad column (vertical) drive outputs, range 2..8.
REQ-003 SHALL have parameter SCAN_DIV, default 192000, clk cycles per column step while scanning, minimum 2.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable scan ticks required to accept a press or a release, minimum 1.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port keypad_hori, input, ROWS, raw row lines, active-low, asynchronous to clk.
REQ-008 SHALL have port keypad_vert, output, COLS, column drive, one-cold (driven column low, others high).
REQ-009 SHALL have port key_code, output, $clog2(ROWS*COLS), accepted key index = row*COLS + col.
REQ-010 SHALL have port key_valid, output, 1, single-clk pulse when a new debounced press is accepted.
REQ-011 SHALL have port key_held, output, 1, high from acceptance until the debounced release completes.

Function
REQ-012 SHALL pass keypad_hori through a 2-flop synchronizer; all decisions SHALL use only the synchronized value.
REQ-013 SHALL generate an internal scan tick: a one-clk pulse every SCAN_DIV clks from a counter that wraps at SCAN_DIV-1.
REQ-014 SHALL implement FSM states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-015 SCAN: on each tick with no active row, rotate the driven column to col+1, wrapping COLS-1 to 0; on a tick with any active row, latch the column and the lowest-index active row, clear the debounce count, and go to PRESS_DB.
REQ-016 PRESS_DB: the column is frozen; on each tick where the lowest active row equals the latched row, increment the count; on a tick with a different row or no row, return to SCAN without advancing the column.
REQ-017 PRESS_DB: when the count reaches DEBOUNCE_CYCLES, go to HELD and, in that same transition, update key_code, assert key_valid for exactly one clk, and set key_held.
REQ-018 HELD: the column is frozen; other keys SHALL be ignored (no rollover); on a tick with no active row, clear the count and go to RELEASE_DB.
REQ-019 RELEASE_DB: on a tick with any active row, return to HELD with no new key_valid; on a tick with no active row, increment the count; at DEBOUNCE_CYCLES, clear key_held, advance the column, and go to SCAN.
REQ-020 key_code SHALL hold its last accepted value until the next acceptance.
REQ-021 Two rows active in the same column SHALL resolve to the lowest row index; this is deterministic with no error.

Reset
REQ-022 While reset=0 SHALL asynchronously set: state SCAN, column 0 driven (keypad_vert = all ones except bit 0 low), key_code 0, key_valid 0, key_held 0, all counters 0, synchronizer flops all ones.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no key_valid pulse; after release, scanning SHALL restart at column 0.

Structure
REQ-024 The FSM state enum and a key_code width function SHALL live in shared package keypad_pkg.
REQ-025 The 2-flop synchronizer SHALL be sub-module row_sync, parametrised by width ROWS; everything else SHALL be in keypad_scan_ctrl.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=3)
REQ-026 Idle, no keys pressed -> keypad_vert cycles 1110, 1101, 1011, 0111, 1110 with 4 clks per step; key_valid stays 0.
REQ-027 Row 2 held low while column 1 is driven, for 3 or more ticks -> exactly one key_valid pulse; key_code = 9; key_held = 1; column frozen at 1101.
REQ-028 Row 2 bouncing (low 1 tick, high 1 tick, repeated) -> no key_valid pulse; scanning resumes from the frozen column.
REQ-029 Key held, then released for 1 tick, then low again -> no second key_valid; key_held stays 1; a full 3-tick release -> key_held = 0 and scanning advances.
REQ-030 Rows 1 and 3 both low in column 0 -> key_code = 4.
REQ-031 reset pulsed low during PRESS_DB -> no key_valid; all outputs at their reset values; scanning restarts at 1110.
